mem_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the fetch port and the data port of the five-stage pipeline.
- Grants at most one access per cycle and tracks the owner of each outstanding read.
- Returns read data exactly one cycle later to the owner.
- Drives stall requests into the hazard unit for the losing requester.
- Data accesses have priority; an anti-starvation counter guarantees fetch progress.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/mem_arb_starve_cnt.sv | 40 ++++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the pipeline memory arbiter.
// Contents:
//   XLEN             - data / address width of the core
//   WAIT_W           - width of the fetch anti-starvation counter
//   MAX_WAIT_DEFAULT - default number of denied fetch cycles before fetch is forced
//   resp_owner_e     - owner of the read response arriving next cycle
package riscv_pkg;

  localparam int XLEN             = 32;
  localparam int WAIT_W           = 4;
  localparam int MAX_WAIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_D    = 2'd2
  } resp_owner_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating counter of consecutive cycles in which the fetch port requested
// but was denied. When it reaches MAX_WAIT, force_if tells the arbiter to
// hand the memory to fetch for one cycle.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   if_req    - fetch request this cycle
//   if_gnt    - fetch granted this cycle
//   force_if  - counter is at MAX_WAIT; fetch must win the next contention
//   wait_cnt  - current counter value
module mem_arb_starve_cnt
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic              if_gnt,
  output logic              force_if,
  output logic [WAIT_W-1:0] wait_cnt
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      if (wait_cnt != MAX_CNT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      // Fetch was served or stopped asking: the starvation streak is over.
      wait_cnt <= '0;
    end
  end

  assign force_if = (wait_cnt == MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch port and
// the data port of a five-stage pipeline. Grants are combinational; read data
// returns to the owner exactly one cycle after the grant. Data has priority,
// but fetch is forced through after MAX_WAIT consecutive denied cycles.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   if_req_i / if_addr_i  - fetch read request and address
//   if_gnt_o              - fetch accepted this cycle
//   if_rvalid_o/if_rdata_o- fetch read response
//   d_req_i, d_we_i, d_wstrb_i, d_addr_i, d_wdata_i - data request
//   d_gnt_o               - data accepted this cycle
//   d_rvalid_o/d_rdata_o  - load response
//   mem_*_o / mem_rdata_i - memory access port (rdata valid one cycle later)
//   stall_if_o, stall_mem_o - stall requests for the losing requester
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [3:0]      d_wstrb_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_wstrb_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            stall_if_o,
  output logic            stall_mem_o
);

  logic              force_if;
  logic [WAIT_W-1:0] wait_cnt;
  resp_owner_e       resp_q;
  resp_owner_e       resp_next;

  mem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req_i),
    .if_gnt   (if_gnt_o),
    .force_if (force_if),
    .wait_cnt (wait_cnt)
  );

  // Priority: data wins unless fetch is also asking and has starved long
  // enough. Nothing is granted while reset is held.
  assign d_gnt_o  = !rst && d_req_i && !(if_req_i && force_if);
  assign if_gnt_o = !rst && if_req_i && !d_gnt_o;

  assign stall_if_o  = if_req_i && !if_gnt_o;
  assign stall_mem_o = d_req_i && !d_gnt_o;

  // Memory port mux; all fields are zero when idle so the memory never sees
  // stale addresses or write data.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_wstrb_o = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (d_gnt_o) begin
      mem_req_o   = 1'b1;
      mem_we_o    = d_we_i;
      mem_wstrb_o = d_we_i ? d_wstrb_i : 4'b0000;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (if_gnt_o) begin
      mem_req_o  = 1'b1;
      mem_addr_o = if_addr_i;
    end
  end

  // Response-owner FSM: rewritten every cycle, so back-to-back reads need no
  // idle cycle. Stores produce no response.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= RESP_NONE;
    end else begin
      resp_q <= resp_next;
    end
  end

  always_comb begin
    resp_next = RESP_NONE;
    if (if_gnt_o) begin
      resp_next = RESP_IF;
    end else if (d_gnt_o && !d_we_i) begin
      resp_next = RESP_D;
    end
  end

  // Gating with rst drops a read whose response would land in a reset cycle.
  assign if_rvalid_o = !rst && (resp_q == RESP_IF);
  assign d_rvalid_o  = !rst && (resp_q == RESP_D);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MAXW = 4;

  typedef struct packed {
    logic        if_v;
    logic        d_v;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i = 1'b0, d_we_i = 1'b0;
  logic [3:0]  d_wstrb_i = '0;
  logic [31:0] d_addr_i = '0, d_wdata_i = '0;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'hBAD0_BAD0;
  logic        stall_if_o, stall_mem_o;

  int n_assert = 0;
  int n_fail   = 0;
  int model_wait = 0;
  resp_t sb[$];
  logic got_if, got_d;

  mem_arbiter #(.XLEN(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_wstrb_i(d_wstrb_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0004) return 32'h0041_8193;
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Memory model: registered read one cycle after an accepted read; garbage otherwise.
  always @(posedge clk)
    mem_rdata_i <= (mem_req_o && !mem_we_o) ? mem_word(mem_addr_o) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus with full comparison of the DUT outputs.
  task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [3:0] ds,
                      input logic [31:0] da, input logic [31:0] dd, input string name);
    logic eg_if, eg_d;
    resp_t e;
    @(posedge clk);
    #1;
    rst = r; if_req_i = ir; if_addr_i = ia;
    d_req_i = dr; d_we_i = dw; d_wstrb_i = ds; d_addr_i = da; d_wdata_i = dd;
    @(negedge clk);
    eg_d  = !r && dr && !(ir && model_wait == MAXW);
    eg_if = !r && ir && !eg_d;
    got_if = if_gnt_o; got_d = d_gnt_o;
    check({name, ".wait_cnt"}, 32'(dut.u_starve.wait_cnt), 32'(model_wait));
    check({name, ".if_gnt"}, 32'(if_gnt_o), 32'(eg_if));
    check({name, ".d_gnt"}, 32'(d_gnt_o), 32'(eg_d));
    check({name, ".stall_if"}, 32'(stall_if_o), 32'(ir && !eg_if));
    check({name, ".stall_mem"}, 32'(stall_mem_o), 32'(dr && !eg_d));
    check({name, ".mem_req"}, 32'(mem_req_o), 32'(eg_if || eg_d));
    check({name, ".mem_we"}, 32'(mem_we_o), 32'(eg_d && dw));
    check({name, ".mem_wstrb"}, 32'(mem_wstrb_o), 32'((eg_d && dw) ? ds : 4'b0));
    check({name, ".mem_addr"}, mem_addr_o, eg_d ? da : (eg_if ? ia : 32'h0));
    check({name, ".mem_wdata"}, mem_wdata_o, eg_d ? dd : 32'h0);
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    else check({name, ".sb_empty"}, 32'(sb.size()), 32'd1);
    if (r) e = '0;
    check({name, ".if_rvalid"}, 32'(if_rvalid_o), 32'(e.if_v));
    check({name, ".d_rvalid"}, 32'(d_rvalid_o), 32'(e.d_v));
    check({name, ".if_rdata"}, if_rdata_o, e.if_v ? e.data : 32'h0);
    check({name, ".d_rdata"}, d_rdata_o, e.d_v ? e.data : 32'h0);
    e = '0;
    if (eg_if) e = '{if_v: 1'b1, d_v: 1'b0, data: mem_word(ia)};
    else if (eg_d && !dw) e = '{if_v: 1'b0, d_v: 1'b1, data: mem_word(da)};
    sb.push_back(e);
    if (r || !ir || eg_if) model_wait = 0;
    else if (model_wait < MAXW) model_wait++;
    $display("[%0t] %s rst=%0b if_gnt=%0b d_gnt=%0b if_rv=%0b d_rv=%0b", $time, name,
             r, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    sb.push_back('0);
    // Reset with both requesters active.
    for (int i = 0; i < 3; i++)
      step(1, 1, 32'h8000_0000, 1, 0, 4'h0, 32'h8000_2000, 32'h0, "reset");
    step(0, 1, 32'h8000_0000, 1, 0, 4'h0, 32'h8000_2000, 32'h0, "post_reset");
    check("post_reset.d_first", 32'(got_d), 32'd1);
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, "idle");
    // Fetch only; response checked next cycle, including the 0x00418193 word.
    step(0, 1, 32'h8000_0004, 0, 0, 4'h0, 32'h0, 32'h0, "fetch_only");
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, "fetch_resp");
    check("fetch_resp.word", if_rdata_o, 32'h0041_8193);
    // Load beats fetch, then store variant.
    step(0, 1, 32'h8000_0008, 1, 0, 4'h0, 32'h8000_1000, 32'h0, "load_beats_fetch");
    step(0, 1, 32'h8000_0008, 1, 1, 4'b0011, 32'h8000_1000, 32'hDEAD_BEEF, "store_beats_fetch");
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, "store_no_resp");
    // Starvation: both requesting for 6 cycles.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 32'h8000_0010, 1, 0, 4'h0, 32'h8000_3000 + 32'(i * 4), 32'h0, "starve");
      check("starve.d_pattern", 32'(got_d), 32'(i != 4));
      check("starve.if_pattern", 32'(got_if), 32'(i == 4));
      check("starve.wait_seq", 32'(dut.u_starve.wait_cnt), (i == 5) ? 32'd0 : 32'(i));
    end
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, "idle");
    // Back-to-back alternating reads.
    step(0, 0, 32'h0, 1, 0, 4'h0, 32'h0000_0100, 32'h0, "b2b_d1");
    step(0, 1, 32'h0000_0200, 0, 0, 4'h0, 32'h0, 32'h0, "b2b_if");
    step(0, 0, 32'h0, 1, 0, 4'h0, 32'h0000_0304, 32'h0, "b2b_d2");
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, "b2b_drain");
    // Misaligned address passes through unchanged.
    step(0, 0, 32'h0, 1, 0, 4'h0, 32'h0000_0403, 32'h0, "misaligned");
    // Reset mid-read: the outstanding load must not be answered.
    step(0, 0, 32'h0, 1, 0, 4'h0, 32'h8000_5000, 32'h0, "mid_read_load");
    step(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, "mid_read_rst");
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, "mid_read_release");
    check("mid_read.resp_q", 32'(dut.resp_q), 32'(riscv_pkg::RESP_NONE));
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, "final_idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
